// File: rtl/mbldcm_commutation_sequencer_pkg.sv
// Shared types and helpers for the BLDC break-before-make commutation sequencer:
// FSM state encoding, six-step gate table and dead-time counter sizing.
`ifndef MF_BLDCM_CLOG2
`define MF_BLDCM_CLOG2(x) $clog2(x)
`endif

package mbldcm_commutation_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEADTIME = 2'd1,
        ST_DRIVE    = 2'd2
    } state_e;

    function automatic logic step_is_valid(input logic [2:0] step);
        return step <= 3'd5;
    endfunction

    // Returns {H[2:0], L[2:0]}; bit0=A, bit1=B, bit2=C. Invalid steps map to all-off.
    function automatic logic [5:0] step_to_gates(input logic [2:0] step);
        case (step)
            3'd0:    return {3'b001, 3'b010};
            3'd1:    return {3'b001, 3'b100};
            3'd2:    return {3'b010, 3'b100};
            3'd3:    return {3'b010, 3'b001};
            3'd4:    return {3'b100, 3'b001};
            3'd5:    return {3'b100, 3'b010};
            default: return 6'b000_000;
        endcase
    endfunction

    function automatic int deadtime_cnt_width(input int dead_cycles);
        return (dead_cycles <= 0) ? 1 : `MF_BLDCM_CLOG2(dead_cycles + 1);
    endfunction

endpackage

// File: rtl/mbldcm_commutation_sequencer_if.sv
// Step request handshake between the commutation-step source and the sequencer.

interface mbldcm_commutation_sequencer_if;
    logic [2:0] iStep;
    logic       iStepValid;
    logic       oStepReady;
    logic       oStepErr;

    modport master (
        output iStep,
        output iStepValid,
        input  oStepReady,
        input  oStepErr
    );

    modport slave (
        input  iStep,
        input  iStepValid,
        output oStepReady,
        output oStepErr
    );
endinterface

// File: rtl/mbldcm_deadtime_timer.sv
// Dead-time counter: start clears and arms it, abort clears it, done flags the last
// dead cycle. With zero dead time, done follows start combinationally.
module mbldcm_deadtime_timer
    import mbldcm_commutation_sequencer_pkg::*;
#(
    parameter int unsigned pDeadTimeCycles = 32'd10
) (
    input  logic iClock,
    input  logic iReset,
    input  logic i_start,
    input  logic i_abort,
    output logic o_done
);

    generate
        if (pDeadTimeCycles == 0) begin : g_bypass
            logic w_unused_bypass;
            assign w_unused_bypass = iClock ^ iReset ^ i_abort;
            assign o_done = i_start;
        end else begin : g_count
            localparam int LP_W = deadtime_cnt_width(int'(pDeadTimeCycles));
            localparam logic [LP_W-1:0] LP_LAST = LP_W'(pDeadTimeCycles - 1);
            localparam logic [LP_W-1:0] LP_MAX  = LP_W'(pDeadTimeCycles);

            logic [LP_W-1:0] r_count;
            logic            r_run;
            logic            w_done;

            assign w_done = r_run & (r_count == LP_LAST);
            assign o_done = w_done;

            // NOTE: state updates in clocked blocks use <= so every register samples
            // pre-edge values regardless of statement order.
            always_ff @(posedge iClock or posedge iReset) begin
                if (iReset) begin
                    r_count <= '0;
                    r_run   <= 1'b0;
                end else if (i_abort) begin
                    r_count <= '0;
                    r_run   <= 1'b0;
                end else if (i_start) begin
                    r_count <= '0;
                    r_run   <= 1'b1;
                end else if (r_run) begin
                    if (w_done) begin
                        r_count <= '0;
                        r_run   <= 1'b0;
                    end else if (r_count != LP_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mbldcm_commutation_sequencer.sv
// Break-before-make six-step commutation sequencer for a three-phase BLDC bridge.
// Define MBLDCM_COMMSEQ_FAULT_LATCH_EN to make iFault sticky until iFaultClear.
module mbldcm_commutation_sequencer
    import mbldcm_commutation_sequencer_pkg::*;
#(
    parameter int unsigned pDeadTimeCycles = 32'd10
) (
    input  logic                                 iClock,
    input  logic                                 iReset,
    input  logic                                 iEnable,
    mbldcm_commutation_sequencer_if.slave        io_step,
    input  logic                                 iFault,
    input  logic                                 iFaultClear,
    output logic [2:0]                           oGateH,
    output logic [2:0]                           oGateL,
    output logic                                 oBusy,
    output logic                                 oFault
);

    state_e     r_state;
    logic [2:0] r_gate_h;
    logic [2:0] r_gate_l;
    logic [5:0] r_pend;
    logic       r_busy;
    logic       r_fault;
    logic       r_step_err;

    state_e     w_state_nxt;
    logic [5:0] w_gates_nxt;
    logic [5:0] w_pend_nxt;
    logic       w_err_nxt;
    logic       w_fault_nxt;

    logic [5:0] w_old;
    logic [5:0] w_new;
    logic [5:0] w_added;
    logic       w_step_ok;
    logic       w_ready;
    logic       w_accept;
    logic       w_block;
    logic       w_start;
    logic       w_timer_done;

    assign w_old     = {r_gate_h, r_gate_l};
    assign w_new     = step_to_gates(io_step.iStep);
    assign w_added   = w_new & ~w_old;
    assign w_step_ok = step_is_valid(io_step.iStep);

    assign w_ready  = ~iReset & iEnable & ~r_fault & (r_state != ST_DEADTIME);
    assign w_accept = io_step.iStepValid & w_ready;
    // A live fault input blocks the same edge it is seen, before the latch catches up.
    assign w_block  = ~iEnable | iFault | r_fault;
    assign w_start  = ~w_block & w_accept & w_step_ok & (w_added != 6'b000_000);

    mbldcm_deadtime_timer #(
        .pDeadTimeCycles(pDeadTimeCycles)
    ) u_deadtime_timer (
        .iClock (iClock),
        .iReset (iReset),
        .i_start(w_start),
        .i_abort(w_block),
        .o_done (w_timer_done)
    );

`ifdef MBLDCM_COMMSEQ_FAULT_LATCH_EN
    assign w_fault_nxt = iFault | (r_fault & ~iFaultClear);
`else
    logic w_unused_fault_clear;
    assign w_unused_fault_clear = iFaultClear;
    assign w_fault_nxt = iFault;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_gates_nxt = w_old;
        w_pend_nxt  = r_pend;
        w_err_nxt   = 1'b0;
        if (w_block) begin
            w_state_nxt = ST_IDLE;
            w_gates_nxt = 6'b000_000;
        end else begin
            case (r_state)
                ST_DEADTIME: begin
                    if (w_timer_done) begin
                        w_state_nxt = ST_DRIVE;
                        w_gates_nxt = r_pend;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (!w_step_ok) begin
                            w_state_nxt = ST_IDLE;
                            w_gates_nxt = 6'b000_000;
                            w_err_nxt   = 1'b1;
                        end else if (w_start && !w_timer_done) begin
                            // Drop leaving switches now; joining ones wait for the dead time.
                            w_state_nxt = ST_DEADTIME;
                            w_gates_nxt = w_old & w_new;
                            w_pend_nxt  = w_new;
                        end else begin
                            w_state_nxt = ST_DRIVE;
                            w_gates_nxt = w_new;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state    <= ST_IDLE;
            r_gate_h   <= 3'b000;
            r_gate_l   <= 3'b000;
            r_pend     <= 6'b000_000;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gate_h   <= w_gates_nxt[5:3];
            r_gate_l   <= w_gates_nxt[2:0];
            r_pend     <= w_pend_nxt;
            r_busy     <= (w_state_nxt == ST_DEADTIME);
            r_fault    <= w_fault_nxt;
            r_step_err <= w_err_nxt;
        end
    end

    assign oGateH             = r_gate_h;
    assign oGateL             = r_gate_l;
    assign oBusy              = r_busy;
    assign oFault             = r_fault;
    assign io_step.oStepReady = w_ready;
    assign io_step.oStepErr   = r_step_err;

    a_no_shoot_through: assert property (
        @(posedge iClock) disable iff (iReset) (r_gate_h & r_gate_l) == 3'b000
    );

endmodule

// File: tb/tb_mbldcm_commutation_sequencer.sv
// Bench for mbldcm_commutation_sequencer: cycle model feeds an expected-output queue,
// plus a second zero-dead-time instance for the single-cycle switchover.
module tb_mbldcm_commutation_sequencer;

    localparam int D = 10;

    typedef struct packed {
        logic [2:0] h;
        logic [2:0] l;
        logic       busy;
        logic       fault;
        logic       err;
    } exp_t;

    logic       iClock = 1'b0;
    logic       iReset;
    logic       en, flt, clr;
    logic [2:0] gh, gl;
    logic       busy, fo;

    logic       en0, flt0, clr0;
    logic [2:0] gh0, gl0;
    logic       busy0, fo0;

    int n_total = 0;
    int n_bad   = 0;

    exp_t exp_q[$];

    int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
    int lo_ph[6] = '{1, 2, 2, 0, 0, 1};

    logic [2:0] m_h, m_l;
    logic       m_busy, m_fault, m_err;
    logic [5:0] m_pend;
    int         m_left;

    always #5 iClock = ~iClock;

    mbldcm_commutation_sequencer_if step_if ();
    mbldcm_commutation_sequencer_if step_if0 ();

    mbldcm_commutation_sequencer #(.pDeadTimeCycles(D)) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iEnable    (en),
        .io_step    (step_if),
        .iFault     (flt),
        .iFaultClear(clr),
        .oGateH     (gh),
        .oGateL     (gl),
        .oBusy      (busy),
        .oFault     (fo)
    );

    mbldcm_commutation_sequencer #(.pDeadTimeCycles(0)) dut0 (
        .iClock     (iClock),
        .iReset     (iReset),
        .iEnable    (en0),
        .io_step    (step_if0),
        .iFault     (flt0),
        .iFaultClear(clr0),
        .oGateH     (gh0),
        .oGateL     (gl0),
        .oBusy      (busy0),
        .oFault     (fo0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [5:0] ref_pat(input int s);
        logic [2:0] h, l;
        h = 3'b001 << hi_ph[s];
        l = 3'b001 << lo_ph[s];
        return {h, l};
    endfunction

    task automatic model_reset();
        m_h = 3'b000; m_l = 3'b000; m_busy = 1'b0; m_fault = 1'b0;
        m_err = 1'b0; m_pend = 6'b0; m_left = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, predict, then compare after the edge.
    task automatic cycle(input logic e, input logic [2:0] s, input logic v,
                         input logic f, input logic c);
        exp_t       ex, got;
        logic       m_ready, f_next;
        logic [5:0] nw, old;
        en = e; step_if.iStep = s; step_if.iStepValid = v; flt = f; clr = c;
        #1;
        m_ready = e & ~m_fault & ~m_busy;
        check("ready", 32'(step_if.oStepReady), 32'(m_ready));
`ifdef MBLDCM_COMMSEQ_FAULT_LATCH_EN
        f_next = f | (m_fault & ~c);
`else
        f_next = f;
`endif
        old   = {m_h, m_l};
        m_err = 1'b0;
        if (!e || f || m_fault) begin
            {m_h, m_l} = 6'b0; m_busy = 1'b0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                {m_h, m_l} = m_pend; m_busy = 1'b0;
            end
        end else if (v && m_ready) begin
            if (s > 3'd5) begin
                {m_h, m_l} = 6'b0; m_err = 1'b1;
            end else begin
                nw = ref_pat(int'(s));
                if ((nw & ~old) != 6'b0 && D > 0) begin
                    {m_h, m_l} = old & nw; m_pend = nw; m_left = D; m_busy = 1'b1;
                end else begin
                    {m_h, m_l} = nw;
                end
            end
        end
        m_fault = f_next;
        ex = '{h: m_h, l: m_l, busy: m_busy, fault: m_fault, err: m_err};
        exp_q.push_back(ex);
        @(posedge iClock);
        @(negedge iClock);
        got = {gh, gl, busy, fo, step_if.oStepErr};
        ex  = exp_q.pop_front();
        check("outputs", 32'(got), 32'(ex));
        check("no_shoot", 32'(gh & gl), 32'd0);
    endtask

    task automatic idle_cycles(input int n, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int         bc;
        logic [2:0] s;
        logic [5:0] p;
        iReset = 1'b1;
        en = 1'b1; flt = 1'b0; clr = 1'b0;
        step_if.iStep = 3'd0; step_if.iStepValid = 1'b1;
        en0 = 1'b0; flt0 = 1'b0; clr0 = 1'b0;
        step_if0.iStep = 3'd0; step_if0.iStepValid = 1'b0;
        model_reset();

        // Reset state, with enable and valid already high.
        @(negedge iClock);
        @(negedge iClock);
        check("rst_outputs", 32'({gh, gl, busy, fo, step_if.oStepErr}), 32'd0);
        check("rst_ready", 32'(step_if.oStepReady), 32'd0);
        iReset = 1'b0;

        // First step from IDLE: D cycles all-off, then A-high/B-low.
        cycle(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        bc = busy ? 1 : 0;
        check("step0_dead_gates", 32'({gh, gl}), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
            if (busy) bc++;
        end
        check("step0_busy_len", 32'(bc), 32'(D));
        check("step0_gates", 32'({gh, gl}), 32'(6'b001_010));

        // Step 0 -> 1: B-low drops at once, C-low joins after D.
        cycle(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        check("step1_overlap", 32'({gh, gl}), 32'(6'b001_000));
        idle_cycles(11, bc);
        check("step1_gates", 32'({gh, gl}), 32'(6'b001_100));

        // Disable four cycles into DEADTIME, then the next step pays the full delay.
        cycle(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        idle_cycles(3, bc);
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("abort_gates", 32'({gh, gl, busy}), 32'd0);
        cycle(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        idle_cycles(12, bc);
        check("restart_busy_len", 32'(bc + 1), 32'(D));
        check("step3_gates", 32'({gh, gl}), 32'(6'b010_001));

        // Invalid step in DRIVE.
        cycle(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        check("err_pulse", 32'({gh, gl, step_if.oStepErr}), 32'd1);
        idle_cycles(1, bc);
        check("err_clear", 32'(step_if.oStepErr), 32'd0);

        // Fault pulse in DRIVE.
        cycle(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        idle_cycles(11, bc);
        cycle(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        check("fault_set", 32'({fo, gh, gl}), 32'(7'b1_000_000));
`ifdef MBLDCM_COMMSEQ_FAULT_LATCH_EN
        idle_cycles(3, bc);
        check("fault_latched", 32'(fo), 32'd1);
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        check("fault_cleared", 32'(fo), 32'd0);
`else
        idle_cycles(1, bc);
        check("fault_level", 32'(fo), 32'd0);
`endif
        cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        idle_cycles(11, bc);
        check("step5_gates", 32'({gh, gl}), 32'(6'b100_010));

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            s = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 5));
            cycle(($urandom_range(0, 19) != 0), s, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
        end

        // Zero dead time: switchover in one edge.
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        en0 = 1'b1; step_if0.iStep = 3'd2; step_if0.iStepValid = 1'b1;
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        check("d0_step2", 32'({gh0, gl0, busy0}), 32'(7'b010_100_0));
        step_if0.iStep = 3'd3;
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        check("d0_step3", 32'({gh0, gl0, busy0}), 32'(7'b010_001_0));
        for (int i = 0; i < 30; i++) begin
            s = 3'($urandom_range(0, 5));
            step_if0.iStep = s;
            #1;
            check("d0_ready", 32'(step_if0.oStepReady), 32'd1);
            cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
            p = ref_pat(int'(s));
            check("d0_out", 32'({gh0, gl0, busy0, fo0, step_if0.oStepErr}), 32'({p, 3'b000}));
            check("d0_no_shoot", 32'(gh0 & gl0), 32'd0);
        end
        step_if0.iStepValid = 1'b0;

        // Reset asserted mid-DEADTIME clears outputs without a clock edge.
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        idle_cycles(11, bc);
        cycle(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        idle_cycles(3, bc);
        check("pre_rst_overlap", 32'({gh, gl, busy}), 32'(7'b001_000_1));
        iReset = 1'b1;
        #1;
        check("rst_async", 32'({gh, gl, busy, fo, step_if.oStepErr}), 32'd0);
        check("rst_async_ready", 32'(step_if.oStepReady), 32'd0);
        model_reset();
        @(negedge iClock);
        iReset = 1'b0;
        cycle(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        idle_cycles(11, bc);
        check("post_rst_gates", 32'({gh, gl}), 32'(6'b010_100));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mbldcm_commutation_sequencer.md
# mbldcm_commutation_sequencer

Break-before-make commutation controller for the three-phase BLDC bridge. Accepts six-step commutation requests over a valid/ready handshake and drives the six gate enables. Switches leaving the conduction pattern turn off first; switches joining it turn on only after a programmable dead time. It sits between the commutation-step source (hall decoder or open-loop stepper) and the per-switch on-delay stage.

## Interface
- pDeadTimeCycles, 32'd10: clock cycles between dropping old switches and enabling new ones; 0 permitted.
- iClock  in  1  system clock, rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iEnable  in  1  bridge enable; low forces all gates off.
- iStep  in  3  requested step, 0..5 valid.
- iStepValid  in  1  request valid.
- oStepReady  out  1  request accepted on the cycle where valid and ready are both high.
- iFault  in  1  external fault (overcurrent/driver fault).
- iFaultClear  in  1  fault latch clear (used only with the macro).
- oGateH  out  3  high-side enables, bit0=A, bit1=B, bit2=C.
- oGateL  out  3  low-side enables, same bit order.
- oBusy  out  1  high while in DEADTIME.
- oFault  out  1  fault active (latched or level, see Configuration).
- oStepErr  out  1  one-cycle pulse when iStep 6/7 is accepted.

## Operation
- Step table, as {high side, low side}: 0={A,B}, 1={A,C}, 2={B,C}, 3={B,A}, 4={C,A}, 5={C,B}.
- States:
  - IDLE: all gates off.
  - DEADTIME: gates = old & new pattern; counter running.
  - DRIVE: gates = current pattern.
- oStepReady = iEnable & ~oFault & (state != DEADTIME). It is combinational and is 0 during reset.
- Accept in IDLE or DRIVE with a valid step:
  - If new & ~old is non-zero and pDeadTimeCycles > 0: enter DEADTIME with the counter at 0.
  - Otherwise: enter DRIVE directly with the new pattern. This covers the same step or a pure turn-off.
- DEADTIME: the counter increments each cycle. When it reaches pDeadTimeCycles-1, the next edge loads the new pattern and enters DRIVE.
- Invalid step (6/7) accepted:
  - Gates off, state goes to IDLE.
  - oStepErr pulses for one cycle.
- Disable: iEnable low at any edge sends the state to IDLE, turns gates off and clears the counter. This aborts DEADTIME.
- Fault active: same effect as disable. No step is accepted.
- Invariant: oGateH[n] & oGateL[n] is never 1 for any phase n.
- Counter width: MF_BLDCM_CLOG2(pDeadTimeCycles+1); saturating, never wraps.

## Timing
- Reset values: oGateH=0, oGateL=0, oBusy=0, oFault=0, oStepErr=0. State is IDLE and the counter is 0.
- All outputs except oStepReady are registered.
- Accept sampled at edge k, with D = pDeadTimeCycles:
  - After edge k, outputs = old & new.
  - After edge k+D, outputs = new.
  - Dropped switches are therefore off for exactly D cycles before any added switch turns on.
- D=0: outputs = new after edge k.
- From IDLE, old=0, so the first step also incurs D cycles of all-off.
- iEnable or fault deassertion with no fault latched: state stays IDLE until the next accepted step.
- Reset asserted mid-DEADTIME: all outputs go to 0 immediately (asynchronous).

## Configuration
- MBLDCM_COMMSEQ_FAULT_LATCH_EN defined:
  - iFault sets a sticky latch. oFault stays high until iFaultClear is high with iFault low.
  - Clear has priority only when iFault is low.
- Undefined:
  - oFault = registered iFault (level-following); iFaultClear is ignored.
  - Operation resumes from IDLE as soon as iFault drops.

## Structure
- Shared header, alongside the existing arithmetic header:
  - state encodings IDLE/DEADTIME/DRIVE;
  - step-to-gate table function, returning a 6-bit {H[2:0], L[2:0]} from a step;
  - reuse of MF_BLDCM_CLOG2.
- One sub-module, mbldcm_deadtime_timer: start/abort inputs and a done output, parameterised by pDeadTimeCycles, with the D=0 bypass inside it.

## Test plan
- Reset, enable, accept step 0 with D=10: gates stay 0 for 10 cycles, then H=001, L=010; oBusy high for exactly those 10 cycles.
- DRIVE step 0 → step 1: H=001 held throughout; L goes 010→000 at k, then 000→100 at k+10; ready low during DEADTIME.
- iEnable dropped 4 cycles into DEADTIME: gates 0 next cycle, oBusy 0, state IDLE; the next step restarts the full 10-cycle delay.
- iStep=7 accepted in DRIVE: gates 0, oStepErr is a single-cycle pulse, ready stays high.
- iFault pulsed for 1 cycle in DRIVE:
  - With the macro: gates stay off and oFault stays 1 until iFaultClear.
  - Without the macro: oFault is 1 for one cycle, then a new step is accepted.
- D=0 build, step 2 → step 3: gates change in one cycle; shoot-through assertion never fires across a random step sequence.
